// File: rtl/captura_operandos.sv
// Parses an ASCII "DD+DD=" stream into four BCD digits for the downstream adder.
// Optional feature: define UN_DIGITO_EN to also accept single-digit operands ("7+8=").
module captura_operandos (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_dato,
   input  logic       rx_listo,
   output logic [3:0] Ad,
   output logic [3:0] Au,
   output logic [3:0] Bd,
   output logic [3:0] Bu,
   output logic       valido,
   output logic       error
);

   typedef enum logic [2:0] {
      E_AD  = 3'd0,
      E_AU  = 3'd1,
      E_MAS = 3'd2,
      E_BD  = 3'd3,
      E_BU  = 3'd4,
      E_FIN = 3'd5
   } estado_t;

   localparam logic [7:0] C_CERO    = 8'h30;
   localparam logic [7:0] C_NUEVE   = 8'h39;
   localparam logic [7:0] C_MAS     = 8'h2B;
   localparam logic [7:0] C_IGUAL   = 8'h3D;
   localparam logic [7:0] C_CR      = 8'h0D;
   localparam logic [7:0] C_ESPACIO = 8'h20;

   estado_t    estado_q;
   logic [3:0] sh_ad_q, sh_au_q, sh_bd_q, sh_bu_q;
   logic [3:0] ad_q, au_q, bd_q, bu_q;
   logic       valido_q, error_q;

   logic       es_digito, es_mas, es_term, es_espacio;
   logic       caracter, acepta, fallo;
   logic [3:0] valor;

   always_comb begin
      es_digito  = (rx_dato >= C_CERO) && (rx_dato <= C_NUEVE);
      es_mas     = (rx_dato == C_MAS);
      es_term    = (rx_dato == C_IGUAL) || (rx_dato == C_CR);
      es_espacio = (rx_dato == C_ESPACIO);
      valor      = rx_dato[3:0];
      // Spaces are transparent: they never reach the state machine.
      caracter   = rx_listo && !es_espacio;
   end

   // Which characters each state accepts; anything else is a parse error.
   always_comb begin
      // NOTE: default assignment first so no path leaves acepta unassigned (no latch).
      acepta = 1'b0;
      case (estado_q)
         E_AD:    acepta = es_digito;
         E_AU: begin
            acepta = es_digito;
`ifdef UN_DIGITO_EN
            if (es_mas) acepta = 1'b1;
`endif
         end
         E_MAS:   acepta = es_mas;
         E_BD:    acepta = es_digito;
         E_BU: begin
            acepta = es_digito;
`ifdef UN_DIGITO_EN
            if (es_term) acepta = 1'b1;
`endif
         end
         E_FIN:   acepta = es_term;
         default: acepta = 1'b0;
      endcase
      fallo = caracter && !acepta;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: every register here is a handful of flops, so all of them are reset.
         estado_q <= E_AD;
         sh_ad_q  <= '0;
         sh_au_q  <= '0;
         sh_bd_q  <= '0;
         sh_bu_q  <= '0;
         ad_q     <= '0;
         au_q     <= '0;
         bd_q     <= '0;
         bu_q     <= '0;
         valido_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         valido_q <= 1'b0;
         error_q  <= 1'b0;
         if (fallo) begin
            error_q  <= 1'b1;
            estado_q <= E_AD;
            sh_ad_q  <= '0;
            sh_au_q  <= '0;
            sh_bd_q  <= '0;
            sh_bu_q  <= '0;
         end else if (caracter) begin
            case (estado_q)
               E_AD: begin
                  sh_ad_q  <= valor;
                  estado_q <= E_AU;
               end
               E_AU: begin
                  if (es_digito) begin
                     sh_au_q  <= valor;
                     estado_q <= E_MAS;
                  end
`ifdef UN_DIGITO_EN
                  else begin
                     // '+' after one digit: that digit was really the units.
                     sh_au_q  <= sh_ad_q;
                     sh_ad_q  <= '0;
                     estado_q <= E_BD;
                  end
`endif
               end
               E_MAS: estado_q <= E_BD;
               E_BD: begin
                  sh_bd_q  <= valor;
                  estado_q <= E_BU;
               end
               E_BU: begin
                  if (es_digito) begin
                     sh_bu_q  <= valor;
                     estado_q <= E_FIN;
                  end
`ifdef UN_DIGITO_EN
                  else begin
                     ad_q     <= sh_ad_q;
                     au_q     <= sh_au_q;
                     bd_q     <= '0;
                     bu_q     <= sh_bd_q;
                     valido_q <= 1'b1;
                     estado_q <= E_AD;
                  end
`endif
               end
               E_FIN: begin
                  ad_q     <= sh_ad_q;
                  au_q     <= sh_au_q;
                  bd_q     <= sh_bd_q;
                  bu_q     <= sh_bu_q;
                  valido_q <= 1'b1;
                  estado_q <= E_AD;
               end
               default: estado_q <= E_AD;
            endcase
         end
      end
   end

   assign Ad     = ad_q;
   assign Au     = au_q;
   assign Bd     = bd_q;
   assign Bu     = bu_q;
   assign valido = valido_q;
   assign error  = error_q;

endmodule

// File: tb/tb_captura_operandos.sv
// Table-driven bench for captura_operandos; expectations follow UN_DIGITO_EN when defined.
module tb_captura_operandos;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_dato;
   logic       rx_listo;
   logic [3:0] Ad, Au, Bd, Bu;
   logic       valido, error;

   int n_comp = 0;
   int n_fail = 0;

   captura_operandos dut (
      .clk      (clk),
      .reset    (reset),
      .rx_dato  (rx_dato),
      .rx_listo (rx_listo),
      .Ad       (Ad),
      .Au       (Au),
      .Bd       (Bd),
      .Bu       (Bu),
      .valido   (valido),
      .error    (error)
   );

   always #5 clk = ~clk;

   // Expected view after the edge that samples the byte: {valido, error, Ad, Au, Bd, Bu}.
   typedef struct {
      logic [7:0]  dato;
      logic        listo;
      logic [17:0] esperado;
   } vec_t;

   vec_t tabla[$];

   task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] requerido);
      n_comp++;
      if (actual !== requerido) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nombre, actual, requerido);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic v, input logic e, input logic [15:0] o);
      vec_t r;
      r.dato     = d;
      r.listo    = 1'b1;
      r.esperado = {v, e, o};
      tabla.push_back(r);
   endtask

   // One byte per cycle: drive on the falling edge, look just after the rising edge.
   task automatic step(input logic [7:0] d, input logic l);
      @(negedge clk);
      rx_dato  = d;
      rx_listo = l;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [17:0] vista();
      return {valido, error, Ad, Au, Bd, Bu};
   endfunction

   initial begin
      logic [15:0] ultimo;

      reset    = 1'b1;
      rx_dato  = 8'h00;
      rx_listo = 1'b0;
      #12;
      check("reset_state", 32'(vista()), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // "12+34="
      push("1", 0, 0, 16'h0000); push("2", 0, 0, 16'h0000); push("+", 0, 0, 16'h0000);
      push("3", 0, 0, 16'h0000); push("4", 0, 0, 16'h0000); push("=", 1, 0, 16'h1234);
      // "1A": error on 'A', outputs held
      push("1", 0, 0, 16'h1234); push("A", 0, 1, 16'h1234);
      // "05+06="
      push("0", 0, 0, 16'h1234); push("5", 0, 0, 16'h1234); push("+", 0, 0, 16'h1234);
      push("0", 0, 0, 16'h1234); push("6", 0, 0, 16'h1234); push("=", 1, 0, 16'h0506);
      // "99 + 99\r" with spaces
      push("9", 0, 0, 16'h0506); push("9", 0, 0, 16'h0506); push(" ", 0, 0, 16'h0506);
      push("+", 0, 0, 16'h0506); push(" ", 0, 0, 16'h0506); push("9", 0, 0, 16'h0506);
      push("9", 0, 0, 16'h0506); push(8'h0D, 1, 0, 16'h9999);
      // digit range edges: '/' and ':' are not digits
      push("/", 0, 1, 16'h9999); push(":", 0, 1, 16'h9999);
      // error in E_MAS, E_BU, E_FIN
      push("1", 0, 0, 16'h9999); push("2", 0, 0, 16'h9999); push("-", 0, 1, 16'h9999);
      push("1", 0, 0, 16'h9999); push("2", 0, 0, 16'h9999); push("+", 0, 0, 16'h9999);
      push("3", 0, 0, 16'h9999); push("x", 0, 1, 16'h9999);
      push("1", 0, 0, 16'h9999); push("2", 0, 0, 16'h9999); push("+", 0, 0, 16'h9999);
      push("3", 0, 0, 16'h9999); push("4", 0, 0, 16'h9999); push("5", 0, 1, 16'h9999);
`ifdef UN_DIGITO_EN
      // "7+8=" and "12+3=" accepted as single-digit operands
      push("7", 0, 0, 16'h9999); push("+", 0, 0, 16'h9999); push("8", 0, 0, 16'h9999);
      push("=", 1, 0, 16'h0708);
      push("1", 0, 0, 16'h0708); push("2", 0, 0, 16'h0708); push("+", 0, 0, 16'h0708);
      push("3", 0, 0, 16'h0708); push("=", 1, 0, 16'h1203);
      ultimo = 16'h1203;
`else
      // "7+8=": '+' is an error, '8' restarts in E_AD, '=' is then an error
      push("7", 0, 0, 16'h9999); push("+", 0, 1, 16'h9999); push("8", 0, 0, 16'h9999);
      push("=", 0, 1, 16'h9999);
      // "12+3=": terminator in E_BU is an error
      push("1", 0, 0, 16'h9999); push("2", 0, 0, 16'h9999); push("+", 0, 0, 16'h9999);
      push("3", 0, 0, 16'h9999); push("=", 0, 1, 16'h9999);
      ultimo = 16'h9999;
`endif

      foreach (tabla[i]) begin
         step(tabla[i].dato, tabla[i].listo);
         check($sformatf("vec%0d_'%s'", i, tabla[i].dato), 32'(vista()), 32'(tabla[i].esperado));
      end

      // Idle with random data mid-expression: no pulses, state held.
      step("5", 1'b1);
      for (int k = 0; k < 20; k++) begin
         step(8'($urandom_range(0, 255)), 1'b0);
         check($sformatf("idle%0d", k), 32'(vista()), {14'h0, 2'b00, ultimo});
      end
      step("6", 1'b1);
      step("+", 1'b1);
      step("7", 1'b1);
      step("8", 1'b1);
      check("before_term", 32'(vista()), {14'h0, 2'b00, ultimo});
      step("=", 1'b1);
      check("after_idle_result", 32'(vista()), {14'h0, 2'b10, 16'h5678});
      step(8'h00, 1'b0);
      check("valido_one_cycle", 32'(vista()), {14'h0, 2'b00, 16'h5678});

      // Reset mid-expression: "12+3", reset, then "4=" errors on '='.
      step("1", 1'b1);
      step("2", 1'b1);
      step("+", 1'b1);
      step("3", 1'b1);
      rx_listo = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", 32'(vista()), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      step("4", 1'b1);
      check("post_reset_4", 32'(vista()), 32'h0);
      step("=", 1'b1);
      check("post_reset_eq_error", 32'(vista()), {14'h0, 2'b01, 16'h0000});
      step(8'h00, 1'b0);
      check("error_one_cycle", 32'(vista()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
      $finish;
   end

endmodule
